expr_result_unpacker: RTL and testbench

//  Receive end of the 90-bit packed expression result bus {y0..y17}.

---
 rtl/expr_result_pkg.sv | 31 +++
 rtl/expr_field_extract.sv | 40 ++++
 rtl/expr_result_unpacker.sv | 112 +++++++++++
 tb/tb_expr_result_unpacker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_result_pkg.sv
// Shared definitions for the packed expression result bus {y0..y17}.
// The 90-bit vector packs 18 fields MSB-first. The width pattern 4,5,6,4,5,6
// repeats three times. Within each group of six, the first three fields are
// unsigned and the last three are signed.
package expr_result_pkg;

    localparam int unsigned NUM_FIELDS = 18;
    localparam int unsigned PACKED_W   = 90;

    localparam int unsigned FIELD_W [NUM_FIELDS] = '{
        4, 5, 6, 4, 5, 6,
        4, 5, 6, 4, 5, 6,
        4, 5, 6, 4, 5, 6
    };

    // y0 occupies [89:86] and y17 occupies [5:0].
    localparam int unsigned FIELD_LSB [NUM_FIELDS] = '{
        86, 81, 75, 71, 66, 60,
        56, 51, 45, 41, 36, 30,
        26, 21, 15, 11,  6,  0
    };

    localparam bit FIELD_SIGNED [NUM_FIELDS] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1
    };

    typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/expr_field_extract.sv
// Combinational field selector for the packed expression result vector.
// Ports:
//   vec        in   PACKED_W  packed vector {y0..y17}
//   idx        in   5         field index 0..17 (other values produce zeros)
//   raw        out  6         field bits, zero-padded to 6 bits
//   ext        out  OUT_W     field extended per its signedness
//   is_signed  out  1         1 = selected field is signed
module expr_field_extract
    import expr_result_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic [PACKED_W-1:0] vec,
    input  logic [4:0]          idx,
    output logic [5:0]          raw,
    output logic [OUT_W-1:0]    ext,
    output logic                is_signed
);

    logic [5:0] mask;
    logic       neg;

    always_comb begin
        raw       = '0;
        mask      = '0;
        is_signed = 1'b0;
        neg       = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx == 5'(i)) begin
                mask      = 6'b11_1111 >> (6 - FIELD_W[i]);
                raw       = 6'(vec >> FIELD_LSB[i]) & mask;
                is_signed = FIELD_SIGNED[i];
                // mask ^ (mask >> 1) isolates the field's top bit.
                neg       = FIELD_SIGNED[i] && ((raw & (mask ^ (mask >> 1))) != 6'd0);
            end
        end
        ext = neg ? (OUT_W'(raw) | ~OUT_W'(mask)) : OUT_W'(raw);
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Receive end of the 90-bit packed expression result bus.
// This module accepts one packed vector per handshake. It streams the 18
// fields out one per cycle, extended to OUT_W and tagged with the field index.
// It folds the raw fields into a rotate-xor signature.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     packed vector valid
//   in_ready     unpacker can accept a vector
//   in_y         packed vector
//   out_valid    field valid
//   out_ready    downstream accepts field
//   out_idx      field index 0..17
//   out_data     extended field value
//   out_signed   field is signed
//   out_last     out_idx == 17
//   csum         signature of the last completed vector
//   csum_valid   one-cycle pulse when csum updates
module expr_result_unpacker
    import expr_result_pkg::*;
#(
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned CSUM_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PACKED_W-1:0] in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_idx,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_signed,
    output logic                out_last,
    output logic [CSUM_W-1:0]   csum,
    output logic                csum_valid
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

    state_t              state_q;
    logic [PACKED_W-1:0] vec_q;
    logic [4:0]          idx_q;
    logic [CSUM_W-1:0]   acc_q;
    logic [CSUM_W-1:0]   acc_d;
    logic [CSUM_W-1:0]   csum_q;
    logic                csum_valid_q;

    logic [5:0]          field_raw;
    logic [OUT_W-1:0]    field_ext;
    logic                field_signed;
    logic                out_hs;
    logic                in_hs;

    expr_field_extract #(
        .OUT_W (OUT_W)
    ) u_extract (
        .vec       (vec_q),
        .idx       (idx_q),
        .raw       (field_raw),
        .ext       (field_ext),
        .is_signed (field_signed)
    );

    always_comb begin
        out_valid  = (state_q == SHIFT);
        out_last   = out_valid && (idx_q == LAST_IDX);
        out_idx    = idx_q;
        out_data   = out_valid ? field_ext : '0;
        out_signed = out_valid && field_signed;
        // Accepting during the final field handshake avoids a bubble between vectors.
        in_ready   = (state_q == IDLE) || (out_last && out_ready);
        out_hs     = out_valid && out_ready;
        in_hs      = in_valid && in_ready;
        acc_d      = {acc_q[CSUM_W-2:0], acc_q[CSUM_W-1]} ^ CSUM_W'(field_raw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            csum_q       <= '0;
            csum_valid_q <= 1'b0;
        end else begin
            csum_valid_q <= 1'b0;
            if (out_hs) begin
                acc_q <= acc_d;
                if (idx_q == LAST_IDX) begin
                    csum_q       <= acc_d;
                    csum_valid_q <= 1'b1;
                    state_q      <= IDLE;
                    idx_q        <= '0;
                end else begin
                    idx_q <= idx_q + 5'd1;
                end
            end
            // A same-cycle accept overrides the return to IDLE.
            if (in_hs) begin
                vec_q   <= in_y;
                idx_q   <= '0;
                acc_q   <= '0;
                state_q <= SHIFT;
            end
        end
    end

    assign csum       = csum_q;
    assign csum_valid = csum_valid_q;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Self-checking bench for expr_result_unpacker with a field/signature scoreboard.
module tb_expr_result_unpacker;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
        logic       sgn;
        logic       last;
    } fld_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [89:0] in_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic [7:0]  out_data;
    logic        out_signed;
    logic        out_last;
    logic [15:0] csum;
    logic        csum_valid;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int csum_pulses = 0;

    logic [89:0] pend_q[$];
    fld_t        exp_q[$];
    logic [15:0] csum_exp_q[$];

    always #5 clk = ~clk;

    expr_result_unpacker #(
        .OUT_W  (8),
        .CSUM_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .out_signed (out_signed),
        .out_last   (out_last),
        .csum       (csum),
        .csum_valid (csum_valid)
    );

    function automatic logic [89:0] rand90();
        return 90'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Independent model: widths 4,5,6 cycling, MSB-first, groups of six u,u,u,s,s,s.
    task automatic model_push(input logic [89:0] v);
        int          pos;
        int          w;
        logic [89:0] sh;
        logic [5:0]  raw;
        logic [7:0]  data;
        logic        sgn;
        logic [15:0] acc;
        fld_t        e;
        pos = 90;
        acc = '0;
        for (int i = 0; i < 18; i++) begin
            w    = 4 + (i % 3);
            pos  = pos - w;
            sh   = v >> pos;
            raw  = sh[5:0] & 6'((1 << w) - 1);
            sgn  = (i % 6) >= 3;
            data = {2'b00, raw};
            if (sgn && raw[w-1]) data = data | (8'hFF << w);
            acc  = {acc[14:0], acc[15]} ^ {10'd0, raw};
            e    = '{idx: 5'(i), data: data, sgn: sgn, last: (i == 17)};
            exp_q.push_back(e);
        end
        csum_exp_q.push_back(acc);
    endtask

    task automatic begin_cycle();
        @(negedge clk);
    endtask

    // Drives the input side, samples #1 later, and scores the handshakes due at the next edge.
    task automatic end_cycle();
        fld_t        e;
        logic [15:0] ec;
        in_valid = (pend_q.size() != 0);
        in_y     = in_valid ? pend_q[0] : rand90();
        #1;
        if (!rst && csum_valid) begin
            csum_pulses++;
            checks++;
            if (csum_exp_q.size() == 0) begin
                errors++;
                $display("FAIL csum_pulse: unexpected csum_valid with csum=%h, want no pulse", csum);
            end else begin
                ec = csum_exp_q.pop_front();
                if (csum !== ec) begin
                    errors++;
                    $display("FAIL csum_value: got %h want %h", csum, ec);
                end
            end
        end
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL field_extra: unexpected field idx=%0d data=%h, want none",
                         out_idx, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_idx, out_data, out_signed, out_last} !== e) begin
                    errors++;
                    $display("FAIL field: got idx=%0d data=%h sgn=%b last=%b want idx=%0d data=%h sgn=%b last=%b",
                             out_idx, out_data, out_signed, out_last, e.idx, e.data, e.sgn, e.last);
                end
            end
        end
        if (!rst && in_valid && in_ready) model_push(pend_q.pop_front());
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0 || csum_exp_q.size() != 0) && n < 200) begin
            begin_cycle();
            out_ready = 1'b1;
            end_cycle();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: %0d fields %0d sums outstanding, want 0",
                     name, exp_q.size(), csum_exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks += 7;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        if (csum !== 16'h0000) begin errors++; $display("FAIL reset_csum: got %h want 0000", csum); end
        if (csum_valid !== 1'b0) begin errors++; $display("FAIL reset_csum_valid: got %b want 0", csum_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int h0 = hs_count;
        int p0 = csum_pulses;
        pend_q.push_back(90'd0);
        drain("zero");
        checks += 3;
        if (hs_count - h0 != 18) begin errors++; $display("FAIL zero_fields: got %0d want 18", hs_count - h0); end
        if (csum_pulses - p0 != 1) begin errors++; $display("FAIL zero_pulses: got %0d want 1", csum_pulses - p0); end
        if (csum !== 16'h0000) begin errors++; $display("FAIL zero_csum: got %h want 0000", csum); end
    endtask

    task automatic test_msb();
        pend_q.push_back(90'd1 << 89);
        drain("msb");
        checks++;
        if (csum !== 16'h0010) begin errors++; $display("FAIL msb_csum: got %h want 0010", csum); end
    endtask

    task automatic test_ones();
        int h0 = hs_count;
        pend_q.push_back('1);
        drain("ones");
        checks++;
        if (hs_count - h0 != 18) begin errors++; $display("FAIL ones_fields: got %0d want 18", hs_count - h0); end
    endtask

    task automatic test_backpressure();
        int   stalls = 0;
        int   n = 0;
        fld_t snap;
        pend_q.push_back(rand90());
        while ((pend_q.size() != 0 || exp_q.size() != 0 || csum_exp_q.size() != 0) && n < 200) begin
            begin_cycle();
            if (out_valid && out_idx == 5'd3 && stalls < 5) begin
                if (stalls == 0) begin
                    snap = '{idx: out_idx, data: out_data, sgn: out_signed, last: out_last};
                end else begin
                    checks++;
                    if ({out_idx, out_data, out_signed, out_last} !== snap) begin
                        errors++;
                        $display("FAIL bp_hold: got idx=%0d data=%h want idx=%0d data=%h",
                                 out_idx, out_data, snap.idx, snap.data);
                    end
                end
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            end_cycle();
            n++;
        end
        checks += 2;
        if (n >= 200) begin errors++; $display("FAIL bp_drain: timeout, want drained"); end
        if (stalls != 5) begin errors++; $display("FAIL bp_stalls: got %0d want 5", stalls); end
    endtask

    task automatic test_back_to_back();
        int h0 = hs_count;
        int n = 0;
        pend_q.push_back(rand90());
        pend_q.push_back(rand90());
        while (hs_count == h0 && n < 10) begin
            begin_cycle();
            out_ready = 1'b1;
            end_cycle();
            n++;
        end
        for (int i = 0; i < 35; i++) begin
            begin_cycle();
            out_ready = 1'b1;
            end_cycle();
        end
        checks++;
        if (hs_count - h0 != 36) begin
            errors++;
            $display("FAIL b2b_rate: got %0d handshakes in 36 cycles want 36", hs_count - h0);
        end
        drain("b2b");
    endtask

    task automatic test_rst_mid();
        logic [15:0] prior;
        int          n = 0;
        int          p0;
        pend_q.push_back(90'd0);
        drain("pre_rst");
        prior = csum;
        p0 = csum_pulses;
        pend_q.push_back(rand90() | 90'd1);
        while (n < 40) begin
            begin_cycle();
            out_ready = 1'b1;
            if (out_valid && out_idx == 5'd7) rst = 1'b1;
            end_cycle();
            n++;
            if (rst) break;
        end
        exp_q.delete();
        csum_exp_q.delete();
        begin_cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks += 6;
        if (n >= 40) begin errors++; $display("FAIL rst_mid_reach: idx 7 not seen, want seen"); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        if (out_idx !== 5'd0) begin errors++; $display("FAIL rst_mid_idx: got %0d want 0", out_idx); end
        if (csum !== prior) begin errors++; $display("FAIL rst_mid_csum: got %h want %h", csum, prior); end
        if (csum_valid !== 1'b0 || csum_pulses != p0) begin
            errors++;
            $display("FAIL rst_mid_pulse: got %b want 0", csum_valid);
        end
        pend_q.push_back(rand90());
        drain("post_rst");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_msb();
        test_ones();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
